// File: rtl/ex_stage.sv
// ---------------------------------------------------------------------------
// ex_stage -- execute stage of an in-order RV64-style pipeline.
//
// Holds the ID/EX and EX/MEM pipeline registers. It also holds the operand
// select muxes, the integer ALU and the branch/flush decision.
//
// Parameters
//   XLEN              datapath width (default 64, must be > 32 for W ops)
//
// Ports
//   clk               clock, rising edge
//   rst               synchronous reset, active low
//   *_id              decode-stage instruction fields, captured into ID/EX
//   flush_id          decode asks for the following EX slot to be squashed
//   fwd1_id/fwd2_id   rs1/rs2 of the decoding instruction equals rd in EX
//   mem_rdata_ex_mem  extended load data from MEM in the current cycle
//   flush_ex          EX-stage flush (combinational)
//   alu_result_ex, rd_ex, sig_op_ex   EX values for forwarding (combinational)
//   *_mem             EX/MEM register outputs
//
// Configuration macro
//   EX_STAGE_LOAD_FWD_EN  when defined, load data from MEM is forwarded into
//                         the operands and the store data. When undefined,
//                         the operands and store data come from rdata_*_ex only.
//
// sig_op bits: 0 reg_wen, 1 is_load, 2 mem_wen, 3 is_branch, 4 is_jal,
//   5 is_jalr, 6 is_auipc, 7 need_imm, 8 is_unsigned, 9 is_ebreak,
//   10 inst_not_ipl, 11 reserved
// ---------------------------------------------------------------------------
module ex_stage #(
  parameter int unsigned XLEN = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [4:0]      alu_op_id,
  input  logic [3:0]      wdt_op_id,
  input  logic [11:0]     sig_op_id,
  input  logic [XLEN-1:0] imm_id,
  input  logic [XLEN-1:0] rdata_1_id,
  input  logic [XLEN-1:0] rdata_2_id,
  input  logic [XLEN-1:0] pc_id,
  input  logic [31:0]     inst_id,
  input  logic [4:0]      rd_id,
  input  logic            flush_id,
  input  logic            fwd1_id,
  input  logic            fwd2_id,
  input  logic [XLEN-1:0] mem_rdata_ex_mem,
  output logic            flush_ex,
  output logic [XLEN-1:0] alu_result_ex,
  output logic [4:0]      rd_ex,
  output logic [11:0]     sig_op_ex,
  output logic            flush_mem,
  output logic [4:0]      rd_mem,
  output logic [11:0]     sig_op_mem,
  output logic [3:0]      wdt_op_mem,
  output logic [XLEN-1:0] alu_result_mem,
  output logic [XLEN-1:0] rdata_2_mem,
  output logic [XLEN-1:0] imm_mem,
  output logic [XLEN-1:0] pc_mem,
  output logic [31:0]     inst_mem
);

  typedef enum logic [4:0] {
    ALU_ADD  = 5'd0,
    ALU_SUB  = 5'd1,
    ALU_SLL  = 5'd2,
    ALU_SLT  = 5'd3,
    ALU_SLTU = 5'd4,
    ALU_XOR  = 5'd5,
    ALU_SRL  = 5'd6,
    ALU_SRA  = 5'd7,
    ALU_OR   = 5'd8,
    ALU_AND  = 5'd9,
    ALU_LUI  = 5'd10,
    ALU_EQ   = 5'd11,
    ALU_NE   = 5'd12,
    ALU_LT   = 5'd13,
    ALU_GE   = 5'd14,
    ALU_LTU  = 5'd15,
    ALU_GEU  = 5'd16,
    ALU_ADDW = 5'd17,
    ALU_SUBW = 5'd18,
    ALU_SLLW = 5'd19,
    ALU_SRLW = 5'd20,
    ALU_SRAW = 5'd21
  } alu_op_e;

  // -------------------------------------------------------------------------
  // ID/EX register
  // -------------------------------------------------------------------------
  logic [4:0]      alu_op_q,  alu_op_d;
  logic [3:0]      wdt_op_q,  wdt_op_d;
  logic [11:0]     sig_op_q,  sig_op_d;
  logic [XLEN-1:0] imm_q,     imm_d;
  logic [XLEN-1:0] rdata_1_q, rdata_1_d;
  logic [XLEN-1:0] rdata_2_q, rdata_2_d;
  logic [XLEN-1:0] pc_q,      pc_d;
  logic [31:0]     inst_q,    inst_d;
  logic [4:0]      rd_q,      rd_d;
  logic            flush_ex_q, flush_ex_d;
  logic            fwd1_q,    fwd1_d;
  logic            fwd2_q,    fwd2_d;

  // -------------------------------------------------------------------------
  // EX/MEM register
  // -------------------------------------------------------------------------
  logic            flush_mem_q,      flush_mem_d;
  logic [4:0]      rd_mem_q,         rd_mem_d;
  logic [11:0]     sig_op_mem_q,     sig_op_mem_d;
  logic [3:0]      wdt_op_mem_q,     wdt_op_mem_d;
  logic [XLEN-1:0] alu_result_mem_q, alu_result_mem_d;
  logic [XLEN-1:0] rdata_2_mem_q,    rdata_2_mem_d;
  logic [XLEN-1:0] imm_mem_q,        imm_mem_d;
  logic [XLEN-1:0] pc_mem_q,         pc_mem_d;
  logic [31:0]     inst_mem_q,       inst_mem_d;

  // -------------------------------------------------------------------------
  // EX datapath signals
  // -------------------------------------------------------------------------
  logic            is_branch_ex;
  logic            is_jal_ex;
  logic            is_auipc_ex;
  logic            need_imm_ex;
  logic            load_fwd1;
  logic            load_fwd2;
  logic [XLEN-1:0] op1;
  logic [XLEN-1:0] op2;
  logic [XLEN-1:0] store_data;
  logic [XLEN-1:0] alu_res;
  logic            flush_ex_w;
  logic [5:0]      shamt;
  logic [4:0]      shamt_w;
  logic [31:0]     w_res;

  assign is_branch_ex = sig_op_q[3];
  assign is_jal_ex    = sig_op_q[4];
  assign is_auipc_ex  = sig_op_q[6];
  assign need_imm_ex  = sig_op_q[7];

`ifdef EX_STAGE_LOAD_FWD_EN
  // The instruction now in MEM is a load that writes a register we read, so
  // the register-file copy is stale. Take the load data arriving this cycle.
  assign load_fwd1 = fwd1_q & sig_op_mem_q[1];
  assign load_fwd2 = fwd2_q & sig_op_mem_q[1];
`else
  logic unused_load_fwd;
  assign unused_load_fwd = ^{fwd1_q, fwd2_q, mem_rdata_ex_mem};
  assign load_fwd1 = 1'b0;
  assign load_fwd2 = 1'b0;
`endif

  always_comb begin
    if (is_auipc_ex || is_jal_ex) begin
      op1 = pc_q;
    end else if (load_fwd1) begin
      op1 = mem_rdata_ex_mem;
    end else begin
      op1 = rdata_1_q;
    end

    if (need_imm_ex) begin
      op2 = imm_q;
    end else if (load_fwd2) begin
      op2 = mem_rdata_ex_mem;
    end else begin
      op2 = rdata_2_q;
    end

    store_data = load_fwd2 ? mem_rdata_ex_mem : rdata_2_q;
  end

  // -------------------------------------------------------------------------
  // ALU
  // -------------------------------------------------------------------------
  function automatic logic [XLEN-1:0] bool_x(input logic b);
    logic [XLEN-1:0] r;
    r    = '0;
    r[0] = b;
    return r;
  endfunction

  function automatic logic [XLEN-1:0] sext32(input logic [31:0] w);
    return {{(XLEN-32){w[31]}}, w};
  endfunction

  assign shamt   = op2[5:0];
  assign shamt_w = op2[4:0];

  // The 32-bit result is computed separately for the W ops. It is then
  // sign-extended once, so the case below stays one line per operation.
  always_comb begin
    w_res = '0;
    case (alu_op_q)
      ALU_ADDW: w_res = op1[31:0] + op2[31:0];
      ALU_SUBW: w_res = op1[31:0] - op2[31:0];
      ALU_SLLW: w_res = op1[31:0] << shamt_w;
      ALU_SRLW: w_res = op1[31:0] >> shamt_w;
      ALU_SRAW: w_res = $signed(op1[31:0]) >>> shamt_w;
      default:  w_res = '0;
    endcase
  end

  always_comb begin
    alu_res = '0;
    case (alu_op_q)
      ALU_ADD:  alu_res = op1 + op2;
      ALU_SUB:  alu_res = op1 - op2;
      ALU_SLL:  alu_res = op1 << shamt;
      ALU_SLT:  alu_res = bool_x($signed(op1) < $signed(op2));
      ALU_SLTU: alu_res = bool_x(op1 < op2);
      ALU_XOR:  alu_res = op1 ^ op2;
      ALU_SRL:  alu_res = op1 >> shamt;
      ALU_SRA:  alu_res = $signed(op1) >>> shamt;
      ALU_OR:   alu_res = op1 | op2;
      ALU_AND:  alu_res = op1 & op2;
      ALU_LUI:  alu_res = op2;
      ALU_EQ:   alu_res = bool_x(op1 == op2);
      ALU_NE:   alu_res = bool_x(op1 != op2);
      ALU_LT:   alu_res = bool_x($signed(op1) < $signed(op2));
      ALU_GE:   alu_res = bool_x($signed(op1) >= $signed(op2));
      ALU_LTU:  alu_res = bool_x(op1 < op2);
      ALU_GEU:  alu_res = bool_x(op1 >= op2);
      ALU_ADDW,
      ALU_SUBW,
      ALU_SLLW,
      ALU_SRLW,
      ALU_SRAW: alu_res = sext32(w_res);
      default:  alu_res = '0;
    endcase
  end

  // A taken branch, or a jump flagged by decode, squashes the next EX slot.
  assign flush_ex_w = flush_ex_q | (is_branch_ex & (alu_res == bool_x(1'b1)));

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    if (flush_ex_w) begin
      alu_op_d   = '0;
      wdt_op_d   = '0;
      sig_op_d   = '0;
      imm_d      = '0;
      rdata_1_d  = '0;
      rdata_2_d  = '0;
      pc_d       = '0;
      inst_d     = '0;
      rd_d       = '0;
      flush_ex_d = 1'b0;
      fwd1_d     = 1'b0;
      fwd2_d     = 1'b0;
    end else begin
      alu_op_d   = alu_op_id;
      wdt_op_d   = wdt_op_id;
      sig_op_d   = sig_op_id;
      imm_d      = imm_id;
      rdata_1_d  = rdata_1_id;
      rdata_2_d  = rdata_2_id;
      pc_d       = pc_id;
      inst_d     = inst_id;
      rd_d       = rd_id;
      flush_ex_d = flush_id;
      fwd1_d     = fwd1_id;
      fwd2_d     = fwd2_id;
    end
  end

  always_comb begin
    flush_mem_d      = flush_ex_w;
    rd_mem_d         = rd_q;
    sig_op_mem_d     = sig_op_q;
    wdt_op_mem_d     = wdt_op_q;
    alu_result_mem_d = alu_res;
    rdata_2_mem_d    = store_data;
    imm_mem_d        = imm_q;
    pc_mem_d         = pc_q;
    inst_mem_d       = inst_q;
  end

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst) begin
      alu_op_q   <= '0;
      wdt_op_q   <= '0;
      sig_op_q   <= '0;
      imm_q      <= '0;
      rdata_1_q  <= '0;
      rdata_2_q  <= '0;
      pc_q       <= '0;
      inst_q     <= '0;
      rd_q       <= '0;
      flush_ex_q <= 1'b0;
      fwd1_q     <= 1'b0;
      fwd2_q     <= 1'b0;
    end else begin
      alu_op_q   <= alu_op_d;
      wdt_op_q   <= wdt_op_d;
      sig_op_q   <= sig_op_d;
      imm_q      <= imm_d;
      rdata_1_q  <= rdata_1_d;
      rdata_2_q  <= rdata_2_d;
      pc_q       <= pc_d;
      inst_q     <= inst_d;
      rd_q       <= rd_d;
      flush_ex_q <= flush_ex_d;
      fwd1_q     <= fwd1_d;
      fwd2_q     <= fwd2_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      flush_mem_q      <= 1'b0;
      rd_mem_q         <= '0;
      sig_op_mem_q     <= '0;
      wdt_op_mem_q     <= '0;
      alu_result_mem_q <= '0;
      rdata_2_mem_q    <= '0;
      imm_mem_q        <= '0;
      pc_mem_q         <= '0;
      inst_mem_q       <= '0;
    end else begin
      flush_mem_q      <= flush_mem_d;
      rd_mem_q         <= rd_mem_d;
      sig_op_mem_q     <= sig_op_mem_d;
      wdt_op_mem_q     <= wdt_op_mem_d;
      alu_result_mem_q <= alu_result_mem_d;
      rdata_2_mem_q    <= rdata_2_mem_d;
      imm_mem_q        <= imm_mem_d;
      pc_mem_q         <= pc_mem_d;
      inst_mem_q       <= inst_mem_d;
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign flush_ex       = flush_ex_w;
  assign alu_result_ex  = alu_res;
  assign rd_ex          = rd_q;
  assign sig_op_ex      = sig_op_q;
  assign flush_mem      = flush_mem_q;
  assign rd_mem         = rd_mem_q;
  assign sig_op_mem     = sig_op_mem_q;
  assign wdt_op_mem     = wdt_op_mem_q;
  assign alu_result_mem = alu_result_mem_q;
  assign rdata_2_mem    = rdata_2_mem_q;
  assign imm_mem        = imm_mem_q;
  assign pc_mem         = pc_mem_q;
  assign inst_mem       = inst_mem_q;

endmodule

// File: tb/tb_ex_stage.sv
// ---------------------------------------------------------------------------
// tb_ex_stage -- scoreboard bench for ex_stage (XLEN = 64).
// A driver issues one stimulus per cycle and pushes the expected EX/MEM view
// into a queue. A monitor pops the queue each cycle and compares the queued
// values with the DUT outputs.
// ---------------------------------------------------------------------------
module tb_ex_stage;
  localparam int unsigned XLEN = 64;
`ifdef EX_STAGE_LOAD_FWD_EN
  localparam bit LFEN = 1'b1;
`else
  localparam bit LFEN = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst;
  logic [4:0]      alu_op_id;
  logic [3:0]      wdt_op_id;
  logic [11:0]     sig_op_id;
  logic [63:0]     imm_id, rdata_1_id, rdata_2_id, pc_id;
  logic [31:0]     inst_id;
  logic [4:0]      rd_id;
  logic            flush_id, fwd1_id, fwd2_id;
  logic [63:0]     mem_rdata_ex_mem;
  logic            flush_ex;
  logic [63:0]     alu_result_ex;
  logic [4:0]      rd_ex;
  logic [11:0]     sig_op_ex;
  logic            flush_mem;
  logic [4:0]      rd_mem;
  logic [11:0]     sig_op_mem;
  logic [3:0]      wdt_op_mem;
  logic [63:0]     alu_result_mem, rdata_2_mem, imm_mem, pc_mem;
  logic [31:0]     inst_mem;

  ex_stage #(.XLEN(XLEN)) dut (
    .clk(clk), .rst(rst),
    .alu_op_id(alu_op_id), .wdt_op_id(wdt_op_id), .sig_op_id(sig_op_id),
    .imm_id(imm_id), .rdata_1_id(rdata_1_id), .rdata_2_id(rdata_2_id),
    .pc_id(pc_id), .inst_id(inst_id), .rd_id(rd_id), .flush_id(flush_id),
    .fwd1_id(fwd1_id), .fwd2_id(fwd2_id), .mem_rdata_ex_mem(mem_rdata_ex_mem),
    .flush_ex(flush_ex), .alu_result_ex(alu_result_ex), .rd_ex(rd_ex),
    .sig_op_ex(sig_op_ex), .flush_mem(flush_mem), .rd_mem(rd_mem),
    .sig_op_mem(sig_op_mem), .wdt_op_mem(wdt_op_mem),
    .alu_result_mem(alu_result_mem), .rdata_2_mem(rdata_2_mem),
    .imm_mem(imm_mem), .pc_mem(pc_mem), .inst_mem(inst_mem)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          rst_n;
    logic [4:0]  alu;
    logic [3:0]  wdt;
    logic [11:0] sig;
    logic [63:0] imm, r1, r2, pc;
    logic [31:0] inst;
    logic [4:0]  rd;
    bit          flush, fwd1, fwd2;
    logic [63:0] mrd;
  } stim_t;

  typedef struct {
    bit          flush;
    logic [4:0]  rd;
    logic [11:0] sig;
    logic [3:0]  wdt;
    logic [63:0] alu, st, imm, pc;
    logic [31:0] inst;
  } mem_t;

  typedef struct {
    bit          ex_flush;
    logic [63:0] ex_alu;
    logic [4:0]  ex_rd;
    logic [11:0] ex_sig;
    mem_t        m;
  } exp_t;

  exp_t  exp_q[$];
  int    n_chk  = 0;
  int    n_fail = 0;

  // Reference pipeline contents: the instruction sitting in EX and in MEM.
  stim_t m_ex;
  mem_t  m_mem;
  bit    m_valid = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] sx32(input logic [31:0] w);
    return {{32{w[31]}}, w};
  endfunction

  function automatic logic [63:0] ref_alu(input logic [4:0] op, input logic [63:0] a, input logic [63:0] b);
    longint sa, sb;
    int     wa;
    sa = a;
    sb = b;
    wa = a[31:0];
    case (op)
      5'd0:  return a + b;
      5'd1:  return a - b;
      5'd2:  return a << b[5:0];
      5'd3:  return (sa < sb) ? 64'd1 : 64'd0;
      5'd4:  return (a < b) ? 64'd1 : 64'd0;
      5'd5:  return a ^ b;
      5'd6:  return a >> b[5:0];
      5'd7:  return sa >>> b[5:0];
      5'd8:  return a | b;
      5'd9:  return a & b;
      5'd10: return b;
      5'd11: return (a == b) ? 64'd1 : 64'd0;
      5'd12: return (a != b) ? 64'd1 : 64'd0;
      5'd13: return (sa < sb) ? 64'd1 : 64'd0;
      5'd14: return (sa >= sb) ? 64'd1 : 64'd0;
      5'd15: return (a < b) ? 64'd1 : 64'd0;
      5'd16: return (a >= b) ? 64'd1 : 64'd0;
      5'd17: return sx32(a[31:0] + b[31:0]);
      5'd18: return sx32(a[31:0] - b[31:0]);
      5'd19: return sx32(a[31:0] << b[4:0]);
      5'd20: return sx32(a[31:0] >> b[4:0]);
      5'd21: return sx32(32'(wa >>> b[4:0]));
      default: return 64'd0;
    endcase
  endfunction

  function automatic stim_t nop();
    stim_t s;
    s = '{default: '0};
    s.rst_n = 1'b1;
    return s;
  endfunction

  function automatic mem_t zero_mem();
    mem_t m;
    m = '{default: '0};
    return m;
  endfunction

  function automatic logic [63:0] pick();
    case ($urandom_range(4))
      0:       return 64'($urandom_range(40));
      1:       return {$urandom, $urandom};
      2:       return 64'h8000_0000_0000_0000;
      3:       return '1;
      default: return 64'h0000_0000_7FFF_FFFF;
    endcase
  endfunction

  function automatic stim_t rand_stim();
    stim_t s;
    s       = nop();
    s.rst_n = ($urandom_range(40) != 0);
    s.alu   = 5'($urandom_range(23));
    s.wdt   = 4'(4'b0001 << $urandom_range(3));
    s.sig   = 12'($urandom);
    s.sig[3] = ($urandom_range(3) == 0);
    s.imm   = pick();
    s.r1    = pick();
    s.r2    = ($urandom_range(2) == 0) ? s.r1 : pick();
    s.pc    = {32'h0, $urandom} & 64'hFFFF_FFFC;
    s.inst  = $urandom;
    s.rd    = 5'($urandom);
    s.flush = ($urandom_range(7) == 0);
    s.fwd1  = 1'($urandom);
    s.fwd2  = 1'($urandom);
    s.mrd   = pick();
    return s;
  endfunction

  // One clock cycle. Drive the inputs on the falling edge and queue what the
  // outputs must show until the next rising edge. Then step the pipeline
  // contents across that edge.
  task automatic cycle(input stim_t s);
    bit          lf1, lf2, taken;
    logic [63:0] op1, op2, res;
    exp_t        e;
    @(negedge clk);
    rst = s.rst_n; alu_op_id = s.alu; wdt_op_id = s.wdt; sig_op_id = s.sig;
    imm_id = s.imm; rdata_1_id = s.r1; rdata_2_id = s.r2; pc_id = s.pc;
    inst_id = s.inst; rd_id = s.rd; flush_id = s.flush;
    fwd1_id = s.fwd1; fwd2_id = s.fwd2; mem_rdata_ex_mem = s.mrd;

    lf1   = LFEN && m_ex.fwd1 && m_mem.sig[1];
    lf2   = LFEN && m_ex.fwd2 && m_mem.sig[1];
    op1   = (m_ex.sig[6] || m_ex.sig[4]) ? m_ex.pc : (lf1 ? s.mrd : m_ex.r1);
    op2   = m_ex.sig[7] ? m_ex.imm : (lf2 ? s.mrd : m_ex.r2);
    res   = ref_alu(m_ex.alu, op1, op2);
    taken = m_ex.flush || (m_ex.sig[3] && res == 64'd1);

    e.ex_flush = taken;
    e.ex_alu   = res;
    e.ex_rd    = m_ex.rd;
    e.ex_sig   = m_ex.sig;
    e.m        = m_mem;
    if (m_valid) exp_q.push_back(e);

    if (!s.rst_n) begin
      m_mem   = zero_mem();
      m_ex    = nop();
      m_ex.rst_n = 1'b0;
      m_valid = 1'b1;
    end else begin
      m_mem.flush = taken;
      m_mem.rd    = m_ex.rd;
      m_mem.sig   = m_ex.sig;
      m_mem.wdt   = m_ex.wdt;
      m_mem.alu   = res;
      m_mem.st    = lf2 ? s.mrd : m_ex.r2;
      m_mem.imm   = m_ex.imm;
      m_mem.pc    = m_ex.pc;
      m_mem.inst  = m_ex.inst;
      m_ex        = taken ? nop() : s;
    end
  endtask

  // Monitor: compares the oldest queued expectation once outputs settle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #3;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("flush_ex",       64'(flush_ex),       64'(e.ex_flush));
        chk("alu_result_ex",  alu_result_ex,        e.ex_alu);
        chk("rd_ex",          64'(rd_ex),           64'(e.ex_rd));
        chk("sig_op_ex",      64'(sig_op_ex),       64'(e.ex_sig));
        chk("flush_mem",      64'(flush_mem),       64'(e.m.flush));
        chk("rd_mem",         64'(rd_mem),          64'(e.m.rd));
        chk("sig_op_mem",     64'(sig_op_mem),      64'(e.m.sig));
        chk("wdt_op_mem",     64'(wdt_op_mem),      64'(e.m.wdt));
        chk("alu_result_mem", alu_result_mem,       e.m.alu);
        chk("rdata_2_mem",    rdata_2_mem,          e.m.st);
        chk("imm_mem",        imm_mem,              e.m.imm);
        chk("pc_mem",         pc_mem,               e.m.pc);
        chk("inst_mem",       64'(inst_mem),        64'(e.m.inst));
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, got %0d expected 0 pending", exp_q.size());
    $fatal(1, "watchdog");
  end

  initial begin
    stim_t s, s2;
    m_ex  = nop();
    m_mem = zero_mem();
    rst = 1'b0; alu_op_id = '0; wdt_op_id = '0; sig_op_id = '0; imm_id = '0;
    rdata_1_id = '0; rdata_2_id = '0; pc_id = '0; inst_id = '0; rd_id = '0;
    flush_id = 1'b0; fwd1_id = 1'b0; fwd2_id = 1'b0; mem_rdata_ex_mem = '0;

    s = nop(); s.rst_n = 1'b0;
    cycle(s); cycle(s);
    cycle(nop()); #2;
    chk("reset_alu_mem", alu_result_mem, 64'd0);
    chk("reset_sig_ex",  64'(sig_op_ex),  64'd0);

    // ADD 5 + 7
    s = nop(); s.r1 = 64'd5; s.r2 = 64'd7; s.rd = 5'd3;
    cycle(s);
    cycle(nop()); #2 chk("add_ex", alu_result_ex, 64'd12);
    cycle(nop()); #2 chk("add_mem", alu_result_mem, 64'd12);

    // SUBW 0 - 1
    s = nop(); s.alu = 5'd18; s.r1 = 64'd0; s.r2 = 64'd1;
    cycle(s);
    cycle(nop()); #2 chk("subw", alu_result_ex, '1);

    // SRA by 63
    s = nop(); s.alu = 5'd7; s.r1 = 64'h8000_0000_0000_0000; s.r2 = 64'd63;
    cycle(s);
    cycle(nop()); #2 chk("sra63", alu_result_ex, '1);

    // AUIPC
    s = nop(); s.sig[6] = 1'b1; s.sig[7] = 1'b1; s.pc = 64'h8000_0000; s.imm = 64'h1000;
    cycle(s);
    cycle(nop()); #2 chk("auipc", alu_result_ex, 64'h8000_1000);

    // BEQ taken squashes the following instruction
    s = nop(); s.sig[3] = 1'b1; s.alu = 5'd11; s.r1 = 64'd9; s.r2 = 64'd9;
    cycle(s);
    s2 = nop(); s2.rd = 5'd7; s2.sig = 12'h001; s2.r1 = 64'd1;
    cycle(s2); #2 chk("beq_flush_ex", 64'(flush_ex), 64'd1);
    cycle(nop()); #2;
    chk("beq_bubble_rd",  64'(rd_ex),     64'd0);
    chk("beq_bubble_sig", 64'(sig_op_ex), 64'd0);
    chk("beq_flush_mem",  64'(flush_mem), 64'd1);

    // Load-use: store data taken from the load result in MEM
    s = nop(); s.sig[0] = 1'b1; s.sig[1] = 1'b1; s.sig[7] = 1'b1;
    s.rd = 5'd4; s.r1 = 64'd100; s.imm = 64'd8;
    cycle(s);
    s = nop(); s.fwd2 = 1'b1; s.r2 = 64'h1234; s.sig[2] = 1'b1; s.sig[7] = 1'b1;
    cycle(s);
    s = nop(); s.mrd = 64'h55;
    cycle(s);
    cycle(nop()); #2 chk("load_use_store", rdata_2_mem, LFEN ? 64'h55 : 64'h1234);

    // Reset with both registers holding live data
    s = nop(); s.r1 = 64'd3; s.rd = 5'd9; s.sig = 12'h001; s.wdt = 4'b0100; s.pc = 64'h44;
    cycle(s); cycle(s);
    s.rst_n = 1'b0;
    cycle(s);
    cycle(nop()); #2;
    chk("rst_mid_rd_mem",  64'(rd_mem),     64'd0);
    chk("rst_mid_alu_mem", alu_result_mem,  64'd0);
    chk("rst_mid_pc_mem",  pc_mem,          64'd0);
    chk("rst_mid_wdt_mem", 64'(wdt_op_mem), 64'd0);
    chk("rst_mid_rd_ex",   64'(rd_ex),      64'd0);
    chk("rst_mid_sig_ex",  64'(sig_op_ex),  64'd0);

    repeat (3000) cycle(rand_stim());
    cycle(nop());
    @(negedge clk);
    #5;
    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/ex_stage.md
EX_STAGE -- requirements
Module: ex_stage

Interface
REQ-001 Parameter: XLEN, default 64, datapath width; all "X" widths below are XLEN.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst  in  1  synchronous, active-low reset (0 = reset).
REQ-004 alu_op_id  in  5  ALU operation code from decode.
REQ-005 wdt_op_id  in  4  memory access width, one-hot (b0 byte, b1 half, b2 word, b3 double); passed through.
REQ-006 sig_op_id  in  12  control bits: 0 reg_wen, 1 is_load, 2 mem_wen, 3 is_branch, 4 is_jal, 5 is_jalr, 6 is_auipc, 7 need_imm, 8 is_unsigned, 9 is_ebreak, 10 inst_not_ipl, 11 reserved.
REQ-007 imm_id / rdata_1_id / rdata_2_id / pc_id  in  X each  immediate, forwarded rs1/rs2 values, PC.
REQ-008 inst_id  in  32  instruction word; rd_id  in  5  destination register.
REQ-009 flush_id  in  1  decode-stage flush flag (jal/jalr).
REQ-010 fwd1_id / fwd2_id  in  1 each  rs1/rs2 matches the rd currently in EX.
REQ-011 mem_rdata_ex_mem  in  X  extended load data from the memory stage, same cycle.
REQ-012 flush_ex  out  1  EX-stage flush, combinational.
REQ-013 alu_result_ex / rd_ex / sig_op_ex  out  X / 5 / 12  EX values for forwarding, combinational.
REQ-014 flush_mem, rd_mem, sig_op_mem, wdt_op_mem, alu_result_mem, rdata_2_mem, imm_mem, pc_mem, inst_mem  out  registered EX/MEM values, widths as their sources.

Function
REQ-015 ID/EX register SHALL capture all *_id inputs each cycle (fwd1/fwd2 stored as fwd1_ex/fwd2_ex, flush_id as flush_ex_q).
REQ-016 ID/EX register SHALL load all-zero (bubble) at the edge where rst=0 or flush_ex=1; flush has priority over capture.
REQ-017 flush_ex SHALL equal flush_ex_q OR (is_branch_ex AND alu_result_ex==1).
REQ-018 load_fwd1 = fwd1_ex AND sig_op_mem[1]; load_fwd2 likewise with fwd2_ex.
REQ-019 op1 SHALL be pc_ex if is_auipc or is_jal, else mem_rdata_ex_mem if load_fwd1, else rdata_1_ex.
REQ-020 op2 SHALL be imm_ex if need_imm, else mem_rdata_ex_mem if load_fwd2, else rdata_2_ex.
REQ-021 ALU, combinational: 0 ADD, 1 SUB, 2 SLL, 3 SLT, 4 SLTU, 5 XOR, 6 SRL, 7 SRA, 8 OR, 9 AND, 10 pass op2 (LUI), 11 EQ, 12 NE, 13 LT, 14 GE, 15 LTU, 16 GEU, 17 ADDW, 18 SUBW, 19 SLLW, 20 SRLW, 21 SRAW; other codes give 0.
REQ-022 Arithmetic wraps modulo 2^XLEN; compares/branches give 1 or 0; shifts use op2[5:0].
REQ-023 W ops SHALL compute on low 32 bits, shift by op2[4:0], sign-extend bit 31 to XLEN.
REQ-024 EX/MEM register SHALL capture flush_ex, rd_ex, sig_op_ex, wdt_op_ex, alu_result_ex, imm_ex, pc_ex, inst_ex and store data = (load_fwd2 ? mem_rdata_ex_mem : rdata_2_ex) every cycle; it is not cleared by flush.
REQ-025 Latency: ID inputs reach *_mem outputs two rising edges later.

Reset
REQ-026 With rst=0 at a rising edge, all ID/EX and EX/MEM state SHALL become 0; registered outputs read 0 the following cycle.
REQ-027 Reset SHALL take effect regardless of flush or in-flight branch; no asynchronous path.

Configuration
REQ-028 Macro EX_STAGE_LOAD_FWD_EN: defined -> REQ-018..020/024 load-data muxes present; undefined -> load_fwd1/2 forced 0, operands and store data use rdata_*_ex only.

Verification
REQ-029 ADD: rdata_1_id=5, rdata_2_id=7, alu_op=0, need_imm=0 -> next cycle alu_result_ex=12; cycle after, alu_result_mem=12.
REQ-030 SUBW: op1=0, op2=1 -> alu_result_ex=0xFFFF_FFFF_FFFF_FFFF; SRA of 0x8000_0000_0000_0000 by 63 -> all ones.
REQ-031 BEQ (is_branch=1, alu_op=11) with equal operands -> flush_ex=1, next edge ID/EX outputs all 0, flush_mem=1.
REQ-032 Load-use: fwd2_id=1 with sig_op_mem[1]=1, mem_rdata_ex_mem=0x55 -> rdata_2_mem=0x55 with macro, rdata_2_ex value without.
REQ-033 AUIPC: pc_id=0x8000_0000, imm_id=0x1000, need_imm=1 -> alu_result_ex=0x8000_1000.
REQ-034 rst=0 mid-stream with valid data in both registers -> all *_mem and *_ex registered values 0 next cycle.
